// File: rtl/uart_receiver_if.sv
// Bundles the serial line and the received-byte outputs of the UART receiver.
// The receiver side uses master; the line driver and consumer side uses slave.
interface uart_receiver_if;
  logic       bit_in;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  bit_in,
    output data_out,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output bit_in,
    input  data_out,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Publishes each correctly framed byte with a one-cycle valid pulse; a bad stop bit gives frame_err.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_receiver_if.master  rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    sync1_d   = rx.bit_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!sync2_q) begin
          state_d   = START;
          bit_cnt_d = 3'd0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_cnt_q] = sync2_q;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break reports once and parks here until the line goes idle
        cnt_d = '0;
        if (sync2_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at CLKS_PER_BIT = 16.
// The line is driven and outputs are observed on falling clock edges.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  int   asrt_cnt;
  int   fail_cnt;
  int   cycle_cnt;
  int   valid_cnt;
  int   ferr_cnt;
  int   overlap_cnt;
  int   fall_cycle;
  int   valid_cycles[$];
  logic [7:0] valid_data[$];

  uart_receiver_if rx_if ();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt = cycle_cnt + 1;

  always @(negedge clk) begin
    if (rx_if.valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cycles.push_back(cycle_cnt);
      valid_data.push_back(rx_if.data_out);
    end
    if (rx_if.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (rx_if.valid === 1'b1 && rx_if.frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
  end

  // Drives one full frame; the start-bit fall cycle is kept for latency checks
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_cycle = cycle_cnt;
    rx_if.bit_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.bit_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_if.bit_in = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_if.bit_in = 1'b1;
    repeat (3) @(negedge clk);
    asrt_cnt++;
    if (rx_if.data_out !== 8'h00) begin
      fail_cnt++;
      $display("[TB] FAIL reset_data_out: got %h expected 00", rx_if.data_out);
    end
    asrt_cnt++;
    if (rx_if.valid !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_valid: got %b expected 0", rx_if.valid);
    end
    asrt_cnt++;
    if (rx_if.frame_err !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_if.frame_err);
    end
    asrt_cnt++;
    if (rx_if.busy !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL reset_busy: got %b expected 0", rx_if.busy);
    end
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_single_frame;
    int v0, e0, lat;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    send_frame(8'h65, 1'b1);
    repeat (20) @(negedge clk);
    asrt_cnt++;
    if (valid_cnt - v0 !== 1) begin
      fail_cnt++;
      $display("[TB] FAIL single_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    asrt_cnt++;
    if (rx_if.data_out !== 8'h65) begin
      fail_cnt++;
      $display("[TB] FAIL single_data: got %h expected 65", rx_if.data_out);
    end
    asrt_cnt++;
    if (ferr_cnt - e0 !== 0) begin
      fail_cnt++;
      $display("[TB] FAIL single_frame_err: got %0d expected 0", ferr_cnt - e0);
    end
    asrt_cnt++;
    if (rx_if.busy !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL single_busy_after: got %b expected 0", rx_if.busy);
    end
    lat = (valid_cycles.size() > 0) ? valid_cycles[valid_cycles.size() - 1] - fall_cycle : -1;
    asrt_cnt++;
    if (lat < 153 || lat > 155) begin
      fail_cnt++;
      $display("[TB] FAIL single_latency: got %0d expected 153..155", lat);
    end
  endtask

  task automatic test_back_to_back;
    int v0, idx, gap;
    v0  = valid_cnt;
    idx = valid_cycles.size();
    send_frame(8'h65, 1'b1);
    send_frame(8'h3E, 1'b1);
    repeat (20) @(negedge clk);
    asrt_cnt++;
    if (valid_cnt - v0 !== 2) begin
      fail_cnt++;
      $display("[TB] FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0);
    end
    if (valid_cycles.size() >= idx + 2) begin
      gap = valid_cycles[idx + 1] - valid_cycles[idx];
      asrt_cnt++;
      if (valid_data[idx] !== 8'h65) begin
        fail_cnt++;
        $display("[TB] FAIL b2b_first_data: got %h expected 65", valid_data[idx]);
      end
      asrt_cnt++;
      if (valid_data[idx + 1] !== 8'h3E) begin
        fail_cnt++;
        $display("[TB] FAIL b2b_second_data: got %h expected 3e", valid_data[idx + 1]);
      end
      asrt_cnt++;
      if (gap !== 160) begin
        fail_cnt++;
        $display("[TB] FAIL b2b_spacing: got %0d expected 160", gap);
      end
    end
    asrt_cnt++;
    if (rx_if.data_out !== 8'h3E) begin
      fail_cnt++;
      $display("[TB] FAIL b2b_data_out: got %h expected 3e", rx_if.data_out);
    end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    rx_if.bit_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_if.bit_in = 1'b1;
    @(negedge clk);
    asrt_cnt++;
    if (rx_if.busy !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL glitch_busy_seen: got %b expected 1", rx_if.busy);
    end
    repeat (11) @(negedge clk);
    asrt_cnt++;
    if (rx_if.busy !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL glitch_busy_clear: got %b expected 0", rx_if.busy);
    end
    repeat (CPB * 11) @(negedge clk);
    asrt_cnt++;
    if (valid_cnt - v0 !== 0) begin
      fail_cnt++;
      $display("[TB] FAIL glitch_valid: got %0d expected 0", valid_cnt - v0);
    end
    asrt_cnt++;
    if (ferr_cnt - e0 !== 0) begin
      fail_cnt++;
      $display("[TB] FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - e0);
    end
  endtask

  task automatic test_break;
    int v0, e0;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (100) @(negedge clk);
    asrt_cnt++;
    if (ferr_cnt - e0 !== 1) begin
      fail_cnt++;
      $display("[TB] FAIL break_frame_err_count: got %0d expected 1", ferr_cnt - e0);
    end
    asrt_cnt++;
    if (rx_if.busy !== 1'b1) begin
      fail_cnt++;
      $display("[TB] FAIL break_busy_held: got %b expected 1", rx_if.busy);
    end
    asrt_cnt++;
    if (rx_if.data_out !== 8'h3E) begin
      fail_cnt++;
      $display("[TB] FAIL break_data_kept: got %h expected 3e", rx_if.data_out);
    end
    rx_if.bit_in = 1'b1;
    repeat (8) @(negedge clk);
    asrt_cnt++;
    if (rx_if.busy !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL break_busy_release: got %b expected 0", rx_if.busy);
    end
    asrt_cnt++;
    if (valid_cnt - v0 !== 0) begin
      fail_cnt++;
      $display("[TB] FAIL break_valid: got %0d expected 0", valid_cnt - v0);
    end
    asrt_cnt++;
    if (ferr_cnt - e0 !== 1) begin
      fail_cnt++;
      $display("[TB] FAIL break_single_err: got %0d expected 1", ferr_cnt - e0);
    end
  endtask

  task automatic test_reset_abort;
    int v0, e0, lat;
    logic [7:0] b;
    b  = 8'h3C;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    rx_if.bit_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_if.bit_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_if.bit_in = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx_if.bit_in = 1'b1;
    @(negedge clk);
    asrt_cnt++;
    if (rx_if.busy !== 1'b0) begin
      fail_cnt++;
      $display("[TB] FAIL abort_busy_in_reset: got %b expected 0", rx_if.busy);
    end
    asrt_cnt++;
    if (rx_if.data_out !== 8'h00) begin
      fail_cnt++;
      $display("[TB] FAIL abort_data_cleared: got %h expected 00", rx_if.data_out);
    end
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    asrt_cnt++;
    if (valid_cnt - v0 !== 0 || ferr_cnt - e0 !== 0) begin
      fail_cnt++;
      $display("[TB] FAIL abort_no_pulse: got valid %0d err %0d expected 0 0", valid_cnt - v0, ferr_cnt - e0);
    end
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    asrt_cnt++;
    if (valid_cnt - v0 !== 1) begin
      fail_cnt++;
      $display("[TB] FAIL abort_resume_valid: got %0d expected 1", valid_cnt - v0);
    end
    asrt_cnt++;
    if (rx_if.data_out !== 8'h3C) begin
      fail_cnt++;
      $display("[TB] FAIL abort_resume_data: got %h expected 3c", rx_if.data_out);
    end
    lat = (valid_cycles.size() > 0) ? valid_cycles[valid_cycles.size() - 1] - fall_cycle : -1;
    asrt_cnt++;
    if (lat < 153 || lat > 155) begin
      fail_cnt++;
      $display("[TB] FAIL abort_resume_latency: got %0d expected 153..155", lat);
    end
  endtask

  task automatic test_no_overlap;
    asrt_cnt++;
    if (overlap_cnt !== 0) begin
      fail_cnt++;
      $display("[TB] FAIL valid_err_overlap: got %0d expected 0", overlap_cnt);
    end
  endtask

  initial begin
    asrt_cnt     = 0;
    fail_cnt     = 0;
    cycle_cnt    = 0;
    valid_cnt    = 0;
    ferr_cnt     = 0;
    overlap_cnt  = 0;
    fall_cycle   = 0;
    rst          = 1'b1;
    rx_if.bit_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_abort();
    test_no_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port bit_in  input  1  serial line, asynchronous to clk, idle high; driven by the transmitter's bit_out.
REQ-005 SHALL have port data_out  output  8  last correctly framed received byte.
REQ-006 SHALL have port valid  output  1  one-cycle pulse; data_out updated this cycle.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL pass bit_in through a 2-flop synchronizer; rx_s is the second flop's output, and all timing below is relative to rx_s.
REQ-010 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: on rx_s==0, SHALL go to START with bit counter cleared.
REQ-013 START: after CLKS_PER_BIT/2 cycles (mid-start-bit), SHALL go to DATA if rx_s==0, else return to IDLE with no output pulse (glitch rejection).
REQ-014 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles (mid-bit) into shift-register bit index 0..7 in order, then go to STOP after the 8th sample.
REQ-015 STOP: CLKS_PER_BIT cycles after the 8th data sample, SHALL sample rx_s.
REQ-016 If the stop-bit sample is 1: in the same cycle, data_out SHALL load the shift register, valid SHALL pulse 1 cycle, and the FSM SHALL go to IDLE.
REQ-017 If the stop-bit sample is 0: frame_err SHALL pulse 1 cycle, data_out SHALL remain unchanged, and the FSM SHALL go to WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL remain until rx_s==1, then go to IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-019 valid and frame_err SHALL never be high in the same cycle.
REQ-020 A start bit arriving on the cycle after return to IDLE SHALL be accepted; back-to-back frames with no idle gap SHALL be received without loss.
REQ-021 The cycle counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and SHALL restart at 0 on each state entry and each data sample.
REQ-022 Latency: valid SHALL assert 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the bit_in falling edge, +/-1 cycle.

Reset
REQ-023 While rst is high at a clock edge: state=IDLE, counters=0, shift register=0, data_out=8'h00, valid=0, frame_err=0, busy=0, and both synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception SHALL resume on the next falling edge after rst is deasserted.

Verification (CLKS_PER_BIT=16)
REQ-025 Frame 0x65 (line 0,1,0,1,0,0,1,1,0,1) -> one valid pulse, data_out=8'h65, frame_err=0, busy low afterwards.
REQ-026 Frames 0x65 then 0x3E back-to-back with no gap -> two valid pulses 160 cycles apart, data_out 8'h65 then 8'h3E.
REQ-027 bit_in low for 4 cycles, then high -> no valid, no frame_err, busy returns to 0 within 12 cycles.
REQ-028 Frame 0xA5 with stop bit 0, line then held low 100 cycles -> one frame_err pulse, data_out keeps its prior value, busy stays high until the line returns high.
REQ-029 rst pulsed during data bit 4 of a frame, followed by a clean frame 0x3C -> no pulse for the aborted frame, then valid with data_out=8'h3C.
